// File: rtl/fma_special_result_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fma_special_result_pkg
//  Description : Shared FPU constants and types for the FMA special-case path.
//                Holds the classifier flag bundle and the stage-1 record.
//  Revision    : 1.0  initial release
// ============================================================================
package fma_special_result_pkg;

  localparam logic [63:0] CANON_NAN64   = 64'h7FF8_0000_0000_0000;
  localparam logic [10:0] EXP_ALLONES64 = 11'h7FF;
  localparam logic [2:0]  RM_RDN        = 3'b010;

  // Flags produced by the upstream operand classifier
  typedef struct packed {
    logic xzero;
    logic yzero;
    logic zzero;
    logic xnan;
    logic ynan;
    logic znan;
    logic xinf;
    logic yinf;
    logic zinf;
  } fma_class_t;

  // Pre-decoded facts carried from stage 1 into the stage-2 result mux
  typedef struct packed {
    logic        ps;        // effective product sign
    logic        zs;        // effective addend sign
    logic        snan_any;  // any operand is a signalling NaN
    logic        nan_any;   // any operand is a NaN
    logic        prodinf;   // product is infinite (no NaN present)
    logic        inv_mul;   // 0 * inf
    logic        inv_add;   // inf - inf
    logic        pzero;     // product is exactly zero
    logic        zzero;     // addend is exactly zero
    logic        zinf;      // addend is infinite
    logic        rdn;       // rounding toward -inf
    logic [63:0] nan_val;   // NaN to emit when a NaN operand is present
    logic [62:0] z_mag;     // addend magnitude for the zero-product case
  } fma_s1_t;

  // Force the quiet bit of a double NaN
  function automatic logic [63:0] quiet_nan(input logic [63:0] v);
    logic [63:0] q;
    q     = v;
    q[51] = 1'b1;
    return q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fma_special_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fma_special_sel
//  Description : Combinational priority mux picking the FMA special-case
//                result, bypass select and invalid flag from stage-1 facts.
//  Revision    : 1.0  initial release
// ============================================================================
module fma_special_sel
  import fma_special_result_pkg::*;
(
  input  fma_s1_t     i_s1,
  output logic        o_use_special,
  output logic [63:0] o_result,
  output logic        o_invalid
);

  // First matching case wins; invalid operations outrank NaN propagation
  always_comb begin
    o_use_special = 1'b1;
    o_result      = '0;
    o_invalid     = 1'b0;
    if (i_s1.inv_mul | i_s1.inv_add) begin
      o_result  = CANON_NAN64;
      o_invalid = 1'b1;
    end else if (i_s1.nan_any) begin
      o_result  = i_s1.nan_val;
      o_invalid = i_s1.snan_any;
    end else if (i_s1.prodinf) begin
      o_result = {i_s1.ps, EXP_ALLONES64, 52'b0};
    end else if (i_s1.zinf) begin
      o_result = {i_s1.zs, EXP_ALLONES64, 52'b0};
    end else if (i_s1.pzero & i_s1.zzero) begin
      // Exact zero sum: like signs keep the sign, unlike signs give -0 only under RDN
      o_result = {((i_s1.ps == i_s1.zs) ? i_s1.ps : i_s1.rdn), 63'b0};
    end else if (i_s1.pzero) begin
      o_result = {i_s1.zs, i_s1.z_mag};
    end else begin
      o_use_special = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fma_special_result.sv
`default_nettype none
// ============================================================================
//  Module      : fma_special_result
//  Description : Two-stage valid/ready pipeline producing the FMA special-case
//                result, bypass select, invalid flag and sticky NV flag.
//  Revision    : 1.0  initial release
// ============================================================================
module fma_special_result
  import fma_special_result_pkg::*;
#(
  parameter bit PROPAGATE_NAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] x,
  input  logic [63:0] y,
  input  logic [63:0] z,
  input  logic        xzero,
  input  logic        yzero,
  input  logic        zzero,
  input  logic        xnan,
  input  logic        ynan,
  input  logic        znan,
  input  logic        xinf,
  input  logic        yinf,
  input  logic        zinf,
  input  logic        negprod,
  input  logic        negz,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        use_special,
  output logic [63:0] special_result,
  output logic        invalid,
  output logic        nv_sticky,
  input  logic        nv_clear
);

  fma_class_t  w_cls;
  fma_s1_t     w_s1;
  fma_s1_t     r_s1;
  logic        r_s1_valid;
  logic        r_s2_valid;
  logic        w_s1_advance;
  logic        w_in_ready;
  logic        w_use_special;
  logic [63:0] w_result;
  logic        w_invalid;
  logic        r_use_special;
  logic [63:0] r_result;
  logic        r_invalid;
  logic        r_nv_sticky;

  assign w_cls = '{xzero: xzero, yzero: yzero, zzero: zzero,
                   xnan: xnan, ynan: ynan, znan: znan,
                   xinf: xinf, yinf: yinf, zinf: zinf};

  assign w_s1_advance = ~r_s2_valid | out_ready;
  assign w_in_ready   = ~r_s1_valid | w_s1_advance;

  // Decode the incoming operand bundle into the stage-1 record
  always_comb begin
    w_s1          = '0;
    w_s1.ps       = x[63] ^ y[63] ^ negprod;
    w_s1.zs       = z[63] ^ negz;
    w_s1.nan_any  = w_cls.xnan | w_cls.ynan | w_cls.znan;
    w_s1.snan_any = (w_cls.xnan & ~x[51]) | (w_cls.ynan & ~y[51]) | (w_cls.znan & ~z[51]);
    w_s1.prodinf  = (w_cls.xinf | w_cls.yinf) & ~w_s1.nan_any;
    w_s1.inv_mul  = (w_cls.xinf & w_cls.yzero) | (w_cls.yinf & w_cls.xzero);
    w_s1.inv_add  = w_s1.prodinf & ~w_s1.inv_mul & w_cls.zinf & (w_s1.ps ^ w_s1.zs);
    w_s1.pzero    = w_cls.xzero | w_cls.yzero;
    w_s1.zzero    = w_cls.zzero;
    w_s1.zinf     = w_cls.zinf;
    w_s1.rdn      = (rm == RM_RDN);
    w_s1.z_mag    = z[62:0];
    // NaN payload source in x, y, z priority order, quieted
    if (!PROPAGATE_NAN)  w_s1.nan_val = CANON_NAN64;
    else if (w_cls.xnan) w_s1.nan_val = quiet_nan(x);
    else if (w_cls.ynan) w_s1.nan_val = quiet_nan(y);
    else                 w_s1.nan_val = quiet_nan(z);
  end

  // Stage 1: capture a bundle whenever the stage is free or draining
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1 <= w_s1;
    end
  end

  fma_special_sel u_sel (
    .i_s1          (r_s1),
    .o_use_special (w_use_special),
    .o_result      (w_result),
    .o_invalid     (w_invalid)
  );

  // Stage 2: register the mux output; hold while downstream stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid    <= 1'b0;
      r_use_special <= 1'b0;
      r_result      <= '0;
      r_invalid     <= 1'b0;
    end else if (w_s1_advance) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_use_special <= w_use_special;
        r_result      <= w_result;
        r_invalid     <= w_invalid;
      end
    end
  end

  // Sticky NV: a consumed invalid result beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_nv_sticky <= 1'b0;
    end else if (r_s2_valid & out_ready & r_invalid) begin
      r_nv_sticky <= 1'b1;
    end else if (nv_clear) begin
      r_nv_sticky <= 1'b0;
    end
  end

  assign in_ready       = w_in_ready;
  assign out_valid      = r_s2_valid;
  assign use_special    = r_use_special;
  assign special_result = r_result;
  assign invalid        = r_invalid;
  assign nv_sticky      = r_nv_sticky;

endmodule
`default_nettype wire

// File: tb/tb_fma_special_result.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fma_special_result
//  Description : Self-checking bench for fma_special_result; two instances
//                (NaN canonicalising and NaN propagating) share one stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fma_special_result;

  localparam logic [63:0] CANON = 64'h7FF8_0000_0000_0000;

  typedef struct {
    logic        us;
    logic [63:0] r0;
    logic [63:0] r1;
    logic        inv;
  } exp_t;

  typedef struct {
    logic [63:0] a, b, c;
    logic        np, nz;
    logic [2:0]  rm;
    logic        us;
    logic [63:0] r0, r1;
    logic        inv;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic nv_clear = 1'b0;
  logic [63:0] x = '0, y = '0, z = '0;
  logic xzero = 0, yzero = 0, zzero = 0, xnan = 0, ynan = 0, znan = 0, xinf = 0, yinf = 0, zinf = 0;
  logic negprod = 0, negz = 0;
  logic [2:0] rm = '0;

  logic        in_ready0, out_valid0, use_special0, invalid0, nv_sticky0;
  logic        in_ready1, out_valid1, use_special1, invalid1, nv_sticky1;
  logic [63:0] special_result0, special_result1;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fma_special_result #(.PROPAGATE_NAN(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .x(x), .y(y), .z(z), .xzero(xzero), .yzero(yzero), .zzero(zzero),
    .xnan(xnan), .ynan(ynan), .znan(znan), .xinf(xinf), .yinf(yinf), .zinf(zinf),
    .negprod(negprod), .negz(negz), .rm(rm), .out_valid(out_valid0), .out_ready(out_ready),
    .use_special(use_special0), .special_result(special_result0), .invalid(invalid0),
    .nv_sticky(nv_sticky0), .nv_clear(nv_clear));

  fma_special_result #(.PROPAGATE_NAN(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .x(x), .y(y), .z(z), .xzero(xzero), .yzero(yzero), .zzero(zzero),
    .xnan(xnan), .ynan(ynan), .znan(znan), .xinf(xinf), .yinf(yinf), .zinf(zinf),
    .negprod(negprod), .negz(negz), .rm(rm), .out_valid(out_valid1), .out_ready(out_ready),
    .use_special(use_special1), .special_result(special_result1), .invalid(invalid1),
    .nv_sticky(nv_sticky1), .nv_clear(nv_clear));

  function automatic bit f_isnan(input logic [63:0] v);
    return (v[62:52] == 11'h7FF) && (v[51:0] != 0);
  endfunction
  function automatic bit f_isinf(input logic [63:0] v);
    return (v[62:52] == 11'h7FF) && (v[51:0] == 0);
  endfunction
  function automatic bit f_iszero(input logic [63:0] v);
    return v[62:0] == 0;
  endfunction

  // Reference: IEEE-754 special-case rules for fused multiply-add
  function automatic exp_t model(input logic [63:0] a, b, c, input logic np, nz, input logic [2:0] r);
    exp_t e;
    logic ps, zs;
    logic [63:0] first;
    e = '{us: 1'b1, r0: 64'h0, r1: 64'h0, inv: 1'b0};
    ps = a[63] ^ b[63] ^ np;
    zs = c[63] ^ nz;
    if ((f_isinf(a) && f_iszero(b)) || (f_isinf(b) && f_iszero(a))) begin
      e.r0 = CANON; e.r1 = CANON; e.inv = 1'b1;
    end else if (f_isnan(a) || f_isnan(b) || f_isnan(c)) begin
      first = f_isnan(a) ? a : (f_isnan(b) ? b : c);
      e.r0  = CANON;
      e.r1  = first | 64'h0008_0000_0000_0000;
      e.inv = (f_isnan(a) && !a[51]) || (f_isnan(b) && !b[51]) || (f_isnan(c) && !c[51]);
    end else if (f_isinf(a) || f_isinf(b)) begin
      if (f_isinf(c) && ps != zs) begin
        e.r0 = CANON; e.r1 = CANON; e.inv = 1'b1;
      end else begin
        e.r0 = {ps, 11'h7FF, 52'b0}; e.r1 = e.r0;
      end
    end else if (f_isinf(c)) begin
      e.r0 = {zs, 11'h7FF, 52'b0}; e.r1 = e.r0;
    end else if ((f_iszero(a) || f_iszero(b)) && f_iszero(c)) begin
      e.r0 = {(ps == zs) ? ps : (r == 3'b010), 63'b0}; e.r1 = e.r0;
    end else if (f_iszero(a) || f_iszero(b)) begin
      e.r0 = {zs, c[62:0]}; e.r1 = e.r0;
    end else begin
      e.us = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    case ($urandom_range(9))
      0: v = 64'h0;
      1: v = 64'h8000_0000_0000_0000;
      2: v = 64'h7FF0_0000_0000_0000;
      3: v = 64'hFFF0_0000_0000_0000;
      4: begin v[62:51] = 12'hFFF; end
      5: begin v[62:52] = 11'h7FF; v[51] = 1'b0; if (v[50:0] == 0) v[0] = 1'b1; end
      6: v = 64'h3FF0_0000_0000_0000;
      7: v = 64'hC000_0000_0000_0000;
      8: begin v[62:52] = 11'h0; if (v[51:0] == 0) v[0] = 1'b1; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic drive_inputs(input logic [63:0] a, b, c, input logic np, nz, input logic [2:0] r);
    x = a; y = b; z = c; negprod = np; negz = nz; rm = r;
    xzero = f_iszero(a); yzero = f_iszero(b); zzero = f_iszero(c);
    xnan = f_isnan(a); ynan = f_isnan(b); znan = f_isnan(c);
    xinf = f_isinf(a); yinf = f_isinf(b); zinf = f_isinf(c);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid0, out_valid1, use_special0, use_special1, invalid0, invalid1, nv_sticky0, nv_sticky1} !== 8'h0 ||
        special_result0 !== 64'h0 || special_result1 !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v%b%b us%b%b inv%b%b nv%b%b r0 %h r1 %h expected all zero",
               out_valid0, out_valid1, use_special0, use_special1, invalid0, invalid1,
               nv_sticky0, nv_sticky1, special_result0, special_result1);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid0 !== 1'b0 || nv_sticky0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got out_valid %b nv_sticky %b expected 0 0", out_valid0, nv_sticky0);
    end
  endtask

  task automatic test_directed();
    vec_t v[10];
    int   lat;
    logic sticky_exp;
    v[0] = '{64'h7FF0000000000000, 64'h0, 64'h3FF0000000000000, 0, 0, 3'b000, 1, CANON, CANON, 1};
    v[1] = '{64'h7FF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, 0, 0, 3'b000, 1, CANON, CANON, 1};
    v[2] = '{64'h7FF0000000000000, 64'h4000000000000000, 64'h7FF0000000000000, 0, 0, 3'b000, 1,
             64'h7FF0000000000000, 64'h7FF0000000000000, 0};
    v[3] = '{64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000005, 0, 0, 3'b000, 1,
             CANON, 64'h7FF8000000000001, 1};
    v[4] = '{64'h0, 64'h4008000000000000, 64'h8000000000000000, 0, 0, 3'b010, 1,
             64'h8000000000000000, 64'h8000000000000000, 0};
    v[5] = '{64'h0, 64'h4008000000000000, 64'h8000000000000000, 0, 0, 3'b000, 1, 64'h0, 64'h0, 0};
    v[6] = '{64'h0, 64'h4008000000000000, 64'hBFF8000000000000, 0, 1, 3'b000, 1,
             64'h3FF8000000000000, 64'h3FF8000000000000, 0};
    v[7] = '{64'h3FF0000000000000, 64'h4000000000000000, 64'h3FF0000000000000, 0, 0, 3'b000, 0, 64'h0, 64'h0, 0};
    v[8] = '{64'h0000000000000001, 64'h3FF0000000000000, 64'h3FF0000000000000, 0, 0, 3'b000, 0, 64'h0, 64'h0, 0};
    v[9] = '{64'h0, 64'hFFF0000000000000, 64'h7FF8000000000003, 0, 0, 3'b000, 1, CANON, CANON, 1};
    sticky_exp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_inputs(v[i].a, v[i].b, v[i].c, v[i].np, v[i].nz, v[i].rm);
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid0 && lat < 10) begin @(negedge clk); lat++; end
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL dir%0d latency: got %0d expected 2", i, lat); end
      n_checks++;
      if (use_special0 !== v[i].us || use_special1 !== v[i].us) begin
        n_fail++; $display("FAIL dir%0d use_special: got %b/%b expected %b", i, use_special0, use_special1, v[i].us);
      end
      n_checks++;
      if (special_result0 !== v[i].r0) begin
        n_fail++; $display("FAIL dir%0d result_canon: got %h expected %h", i, special_result0, v[i].r0);
      end
      n_checks++;
      if (special_result1 !== v[i].r1) begin
        n_fail++; $display("FAIL dir%0d result_prop: got %h expected %h", i, special_result1, v[i].r1);
      end
      n_checks++;
      if (invalid0 !== v[i].inv || invalid1 !== v[i].inv) begin
        n_fail++; $display("FAIL dir%0d invalid: got %b/%b expected %b", i, invalid0, invalid1, v[i].inv);
      end
      sticky_exp = sticky_exp | v[i].inv;
      @(negedge clk);
      n_checks++;
      if (nv_sticky0 !== sticky_exp || nv_sticky1 !== sticky_exp) begin
        n_fail++; $display("FAIL dir%0d nv_sticky: got %b/%b expected %b", i, nv_sticky0, nv_sticky1, sticky_exp);
      end
    end
  endtask

  task automatic test_sticky_clear_set();
    int lat;
    @(negedge clk);
    drive_inputs(64'h0, 64'h7FF0000000000000, 64'h3FF0000000000000, 0, 0, 3'b000);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid0 && lat < 10) begin @(negedge clk); lat++; end
    nv_clear = 1'b1;
    @(negedge clk);
    n_checks++;
    if (nv_sticky0 !== 1'b1 || nv_sticky1 !== 1'b1) begin
      n_fail++; $display("FAIL sticky_set_beats_clear: got %b/%b expected 1", nv_sticky0, nv_sticky1);
    end
    @(negedge clk);
    nv_clear = 1'b0;
    n_checks++;
    if (nv_sticky0 !== 1'b0 || nv_sticky1 !== 1'b0) begin
      n_fail++; $display("FAIL sticky_clear: got %b/%b expected 0", nv_sticky0, nv_sticky1);
    end
  endtask

  task automatic test_back_to_back();
    int   sent, recv;
    bit   dropped, prev_stall;
    logic [63:0] prev_r0;
    logic prev_ov;
    exp_t e;
    logic [63:0] zv;
    sent = 0; recv = 0; dropped = 0; prev_stall = 0; prev_r0 = '0; prev_ov = 0;
    sb.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      zv = 64'h3FF0000000000000 + 64'(sent);
      drive_inputs(64'h0, 64'h3FF0000000000000, zv, 0, 0, 3'b000);
      in_valid  = (sent < 4);
      out_ready = !(c >= 3 && c <= 5);
      #1;
      n_checks++;
      if (in_ready0 !== !(sb.size() == 2 && !out_ready)) begin
        n_fail++; $display("FAIL b2b_in_ready c%0d: got %b expected %b", c, in_ready0, !(sb.size() == 2 && !out_ready));
      end
      if (!in_ready0) dropped = 1;
      if (prev_stall) begin
        n_checks++;
        if (out_valid0 !== prev_ov || special_result0 !== prev_r0) begin
          n_fail++; $display("FAIL b2b_stall_hold c%0d: got %b %h expected %b %h", c, out_valid0, special_result0, prev_ov, prev_r0);
        end
      end
      if (out_valid0 && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_output c%0d: got %h expected none", c, special_result0);
        end else begin
          e = sb.pop_front();
          recv++;
          if (special_result0 !== e.r0 || special_result1 !== e.r1) begin
            n_fail++; $display("FAIL b2b_order c%0d: got %h/%h expected %h/%h", c, special_result0, special_result1, e.r0, e.r1);
          end
        end
      end
      if (in_valid && in_ready0) begin
        sb.push_back(model(x, y, z, negprod, negz, rm));
        sent++;
      end
      prev_stall = out_valid0 && !out_ready;
      prev_ov = out_valid0; prev_r0 = special_result0;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!dropped) begin n_fail++; $display("FAIL b2b_in_ready_drop: got never-low expected a low cycle"); end
    n_checks++;
    if (recv !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", recv); end
  endtask

  task automatic test_random();
    logic sticky_m, prev_stall, prev_us, prev_inv;
    logic [63:0] prev_r0, prev_r1;
    exp_t e;
    bit popped;
    sticky_m = nv_sticky0;  // state left by previous test; cross-checked against DUT1
    n_checks++;
    if (nv_sticky1 !== sticky_m) begin n_fail++; $display("FAIL rnd_sticky_start: got %b expected %b", nv_sticky1, sticky_m); end
    prev_stall = 0; prev_us = 0; prev_inv = 0; prev_r0 = '0; prev_r1 = '0;
    sb.delete();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      drive_inputs(pick(), pick(), pick(), 1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(7)));
      in_valid  = (c < 1480) && ($urandom_range(3) != 0);
      out_ready = (c >= 1480) || ($urandom_range(2) != 0);
      nv_clear  = ($urandom_range(15) == 0);
      #1;
      n_checks++;
      if (in_ready0 !== !(sb.size() == 2 && !out_ready) || in_ready1 !== in_ready0) begin
        n_fail++; $display("FAIL rnd_in_ready c%0d: got %b/%b expected %b", c, in_ready0, in_ready1, !(sb.size() == 2 && !out_ready));
      end
      n_checks++;
      if (nv_sticky0 !== sticky_m || nv_sticky1 !== sticky_m) begin
        n_fail++; $display("FAIL rnd_sticky c%0d: got %b/%b expected %b", c, nv_sticky0, nv_sticky1, sticky_m);
      end
      if (prev_stall) begin
        n_checks++;
        if (!out_valid0 || use_special0 !== prev_us || invalid0 !== prev_inv ||
            special_result0 !== prev_r0 || special_result1 !== prev_r1) begin
          n_fail++; $display("FAIL rnd_stall_hold c%0d: got %b %h/%h expected 1 %h/%h", c, out_valid0, special_result0, special_result1, prev_r0, prev_r1);
        end
      end
      popped = 0;
      if (out_valid0 && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra_output c%0d: got %h expected none", c, special_result0);
        end else begin
          e = sb.pop_front();
          popped = 1;
          if (use_special0 !== e.us || use_special1 !== e.us || special_result0 !== e.r0 ||
              special_result1 !== e.r1 || invalid0 !== e.inv || invalid1 !== e.inv) begin
            n_fail++;
            $display("FAIL rnd_result c%0d: got us%b%b inv%b%b %h/%h expected us%b inv%b %h/%h", c,
                     use_special0, use_special1, invalid0, invalid1, special_result0, special_result1,
                     e.us, e.inv, e.r0, e.r1);
          end
        end
      end
      if (popped && e.inv) sticky_m = 1'b1;
      else if (nv_clear)   sticky_m = 1'b0;
      if (in_valid && in_ready0) sb.push_back(model(x, y, z, negprod, negz, rm));
      prev_stall = out_valid0 && !out_ready;
      prev_us = use_special0; prev_inv = invalid0; prev_r0 = special_result0; prev_r1 = special_result1;
    end
    nv_clear = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d outstanding expected 0", sb.size()); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    drive_inputs(64'h7FF0000000000000, 64'h0, 64'h3FF0000000000000, 0, 0, 3'b000);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (nv_sticky0 !== 1'b1) begin n_fail++; $display("FAIL mid_sticky_pre: got %b expected 1", nv_sticky0); end
    out_ready = 1'b0;
    drive_inputs(64'h7FF0000000000000, 64'h0, 64'h3FF0000000000000, 0, 0, 3'b000);
    in_valid = 1'b1;
    @(negedge clk);
    drive_inputs(64'h3FF0000000000000, 64'h4000000000000000, 64'h3FF0000000000000, 0, 0, 3'b000);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin
      n_fail++; $display("FAIL mid_full: got out_valid %b in_ready %b expected 1 0", out_valid0, in_ready0);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || nv_sticky0 !== 1'b0 || nv_sticky1 !== 1'b0 ||
        special_result0 !== 64'h0 || use_special0 !== 1'b0 || invalid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async_reset: got v%b%b nv%b%b us%b inv%b r %h expected all zero",
               out_valid0, out_valid1, nv_sticky0, nv_sticky1, use_special0, invalid0, special_result0);
    end
    @(negedge clk);
    reset_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL mid_flushed c%0d: got out_valid %b expected 0", c, out_valid0); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sticky_clear_set();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fma_special_result.md
Name: fma_special_result

Overview:
- Downstream consumer of the FMA operand classifier (zero/NaN/inf/denorm flags on x, y, z).
- Turns those flags plus raw operands into the final special-case result, the use-special select and the invalid flag for the FMA result mux.
- Two-stage valid/ready pipeline.
- Keeps a sticky invalid accumulator for the FCSR path.

Parameters:
- PROPAGATE_NAN, 0, 1 = quiet and propagate first NaN payload (priority x, y, z); 0 = always emit canonical NaN 64'h7FF8_0000_0000_0000.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/flag bundle valid
- in_ready  out  1  block can accept bundle
- x, y, z  in  64 each  raw double operands
- xzero, yzero, zzero, xnan, ynan, znan, xinf, yinf, zinf  in  1 each  classifier flags
- negprod  in  1  negate product (FNMADD/FNMSUB)
- negz  in  1  negate addend (FMSUB/FNMADD)
- rm  in  3  rounding mode (RISC-V encoding; 3'b010 = RDN)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- use_special  out  1  result must bypass main datapath
- special_result  out  64  special-case result
- invalid  out  1  NV for this op
- nv_sticky  out  1  OR of invalid over accepted results since clear
- nv_clear  in  1  synchronous clear of nv_sticky

Behaviour:
- Reset (async, reset_n low): both stage valids 0; out_valid=0, use_special=0, special_result=0, invalid=0, nv_sticky=0. in_ready may be 1 during reset.
- Handshake:
  - Transfer on valid&ready.
  - in_ready = ~s1_valid | s1_advance, where s1_advance = ~s2_valid | out_ready.
  - Stage 2 loads when s1_valid & s1_advance.
  - Outputs hold stable while out_valid & ~out_ready.
  - Latency 2 cycles; throughput 1/cycle with out_ready high.
- Stage 1 registers:
  - ps = x[63]^y[63]^negprod; zs = z[63]^negz.
  - snan_any = (xnan&~x[51]) | (ynan&~y[51]) | (znan&~z[51]).
  - nan_any = xnan | ynan | znan.
  - prodinf = (xinf|yinf) & ~nan_any.
  - inv_mul = (xinf&yzero) | (yinf&xzero).
  - inv_add = prodinf & ~inv_mul & zinf & (ps != zs).
  - pzero = xzero | yzero.
  - Selected NaN source (PROPAGATE_NAN=1): first NaN in x, y, z order, with bit 51 forced to 1.
  - zero-case operands.
- Stage 2 result priority (first match wins):
  1. inv_mul | inv_add: result canonical NaN, invalid=1.
  2. nan_any: result canonical NaN, or the propagated NaN if PROPAGATE_NAN=1; invalid=snan_any.
  3. prodinf: result {ps, 11'h7FF, 52'b0}.
  4. zinf: result {zs, 11'h7FF, 52'b0}.
  5. pzero & zzero: sign = ps if ps==zs, else (rm==3'b010); result {sign, 63'b0}.
  6. pzero & ~zzero: result {zs, z[62:0]}.
  7. Otherwise: use_special=0, special_result=0, invalid=0.
  - use_special=1 for cases 1–6.
  - Case 1 takes precedence over case 2 when a NaN coexists with 0*inf (invalid=1).
- nv_sticky:
  - Sets on an out_valid&out_ready cycle with invalid=1.
  - nv_clear in the same cycle as a set: set wins (clear then set).
  - Otherwise nv_clear clears it.
- Denormal inputs are not zero (xzero etc. are true zeros only); they fall to case 7 unless another case applies.
- Reset asserted mid-flight drops both stages with no output.

Decomposition:
- Shared FPU package: constants CANON_NAN64, EXP_ALLONES64=11'h7FF, RM_RDN=3'b010, and a packed struct for the classifier flag bundle (x/y/z zero, nan, inf).
- One natural sub-module, fma_special_sel: combinational stage-2 priority mux. The top keeps the pipeline registers, handshake and sticky flag.

Test Plan:
- x=+inf (7FF0..0), y=+0, z=1.0, out_ready=1: result 7FF8000000000000, use_special=1, invalid=1 after 2 cycles; nv_sticky=1 the next cycle.
- x=+inf, y=2.0 (4000..0), z=-inf, negprod=negz=0: inv_add, canonical NaN, invalid=1. Same with z=+inf: result 7FF0000000000000, invalid=0.
- x=sNaN 7FF0000000000001, y=1.0, z=qNaN 7FF8000000000005:
  - PROPAGATE_NAN=0: 7FF8000000000000, invalid=1.
  - PROPAGATE_NAN=1: 7FF8000000000001.
- x=+0, y=3.0, z=-0, rm=RDN: result 8000000000000000; rm=RNE (000): 0000000000000000. z=-1.5 (BFF8..0), negz=1: result 3FF8000000000000.
- Back-to-back 4 bundles, out_ready low for cycles 3–5:
  - in_ready drops once both stages are full.
  - out_valid/special_result stay stable while stalled.
  - All 4 results emerge in order, none lost or duplicated.
- reset_n pulsed low with both stages full: out_valid=0 immediately (async) and nv_sticky=0; nv_clear and a set in the same cycle leave nv_sticky=1.
